// File: rtl/alu_arbiter_if.sv
// Request, ALU-side and response signals shared between alu_arbiter and its neighbours.
// slave is the arbiter's view; master is the view of the requesters, ALU and consumer.
interface alu_arbiter_if;
  logic        i_req0_valid;
  logic        o_req0_ready;
  logic [31:0] i_req0_a;
  logic [31:0] i_req0_b;
  logic [2:0]  i_req0_funct3;
  logic        i_req0_alt;
  logic        i_req1_valid;
  logic        o_req1_ready;
  logic [31:0] i_req1_a;
  logic [31:0] i_req1_b;
  logic [2:0]  i_req1_funct3;
  logic        i_req1_alt;
  logic [31:0] o_alu_a;
  logic [31:0] o_alu_b;
  logic [2:0]  o_alu_op;
  logic [31:0] i_alu_result;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_data;
  logic        o_rsp_id;

  modport slave (
    input  i_req0_valid, i_req0_a, i_req0_b,
    input  i_req0_funct3, i_req0_alt,
    input  i_req1_valid, i_req1_a, i_req1_b,
    input  i_req1_funct3, i_req1_alt,
    input  i_alu_result, i_rsp_ready,
    output o_req0_ready, o_req1_ready,
    output o_alu_a, o_alu_b, o_alu_op,
    output o_rsp_valid, o_rsp_data, o_rsp_id
  );

  modport master (
    output i_req0_valid, i_req0_a, i_req0_b,
    output i_req0_funct3, i_req0_alt,
    output i_req1_valid, i_req1_a, i_req1_b,
    output i_req1_funct3, i_req1_alt,
    output i_alu_result, i_rsp_ready,
    input  o_req0_ready, o_req1_ready,
    input  o_alu_a, o_alu_b, o_alu_op,
    input  o_rsp_valid, o_rsp_data, o_rsp_id
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one registered ALU between two RV32I requesters.
// Define ALU_ARBITER_SRA_EN to add sign fill for SRA; otherwise SRA acts as SRL.
module alu_arbiter #(
  parameter bit RESET_PRIORITY = 1'b0,
  parameter int SHAMT_W        = 5
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  alu_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  localparam logic [31:0] SH_MASK =
    32'((64'd1 << SHAMT_W) - 64'd1);

  function automatic logic [31:0] rev32(
    input logic [31:0] x
  );
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[31-i];
    return r;
  endfunction

  state_t      state_q, state_d;
  logic        prio_q;
  logic        id_q;
  logic        rev_q;
  logic        rsp_id_q;
  logic [31:0] data_q;

  logic        any, gnt, acc;
  logic        rdy0, rdy1;
  logic [31:0] sel_a, sel_b;
  logic [2:0]  sel_f3;
  logic        sel_alt;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_op;
  logic        rev_d;
  logic [31:0] res;

`ifdef ALU_ARBITER_SRA_EN
  logic               sra_d;
  logic               sra_q;
  logic               a31_q;
  logic [SHAMT_W-1:0] shamt_q;
`endif

  always_comb begin
    state_d = state_q;
    any     = bus.i_req0_valid | bus.i_req1_valid;
    gnt     = 1'b0;
    rdy0    = 1'b0;
    rdy1    = 1'b0;
    acc     = 1'b0;
    alu_a   = '0;
    alu_b   = '0;
    alu_op  = 3'b000;
    rev_d   = 1'b0;
`ifdef ALU_ARBITER_SRA_EN
    sra_d   = 1'b0;
`endif
    // Contention goes to the priority holder.
    if (bus.i_req0_valid && bus.i_req1_valid) gnt = prio_q;
    else gnt = bus.i_req1_valid;
    sel_a   = gnt ? bus.i_req1_a      : bus.i_req0_a;
    sel_b   = gnt ? bus.i_req1_b      : bus.i_req0_b;
    sel_f3  = gnt ? bus.i_req1_funct3 : bus.i_req0_funct3;
    sel_alt = gnt ? bus.i_req1_alt    : bus.i_req0_alt;
    unique case (state_q)
      IDLE: begin
        if (any) begin
          acc     = 1'b1;
          rdy0    = ~gnt;
          rdy1    = gnt;
          state_d = EXEC;
          alu_a   = sel_a;
          alu_b   = sel_b;
          unique case (sel_f3)
            3'b000: begin
              alu_op = 3'b000;
              if (sel_alt) alu_b = ~sel_b + 32'd1;
            end
            // SLL runs as SRL on the reversed operand.
            3'b001: begin
              alu_op = 3'b101;
              alu_a  = rev32(sel_a);
              alu_b  = sel_b & SH_MASK;
              rev_d  = 1'b1;
            end
            3'b010: alu_op = 3'b010;
            3'b011: alu_op = 3'b011;
            3'b100: alu_op = 3'b100;
            3'b101: begin
              alu_op = 3'b101;
              alu_b  = sel_b & SH_MASK;
`ifdef ALU_ARBITER_SRA_EN
              sra_d  = sel_alt;
`endif
            end
            3'b110: alu_op = 3'b110;
            3'b111: alu_op = 3'b111;
            default: alu_op = 3'b000;
          endcase
        end
      end
      EXEC: state_d = RESP;
      RESP: if (bus.i_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    res = rev_q ? rev32(bus.i_alu_result)
                : bus.i_alu_result;
`ifdef ALU_ARBITER_SRA_EN
    if (sra_q && a31_q)
      res = res | ~(32'hFFFF_FFFF >> shamt_q);
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      prio_q   <= RESET_PRIORITY;
      id_q     <= 1'b0;
      rev_q    <= 1'b0;
      rsp_id_q <= 1'b0;
      data_q   <= '0;
`ifdef ALU_ARBITER_SRA_EN
      sra_q    <= 1'b0;
      a31_q    <= 1'b0;
      shamt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (acc) begin
        id_q   <= gnt;
        rev_q  <= rev_d;
        prio_q <= ~gnt;
`ifdef ALU_ARBITER_SRA_EN
        sra_q   <= sra_d;
        a31_q   <= sel_a[31];
        shamt_q <= sel_b[SHAMT_W-1:0];
`endif
      end
      if (state_q == EXEC) begin
        data_q   <= res;
        rsp_id_q <= id_q;
      end
    end
  end

  assign bus.o_req0_ready = rdy0;
  assign bus.o_req1_ready = rdy1;
  assign bus.o_alu_a      = alu_a;
  assign bus.o_alu_b      = alu_b;
  assign bus.o_alu_op     = alu_op;
  assign bus.o_rsp_valid  = (state_q == RESP);
  assign bus.o_rsp_data   = data_q;
  assign bus.o_rsp_id     = rsp_id_q;

endmodule
